// File: rtl/router.sv
// router: multi-base arithmetic unit dispatcher.
//
// Runs continuously through IDLE -> EXEC -> DONE -> IDLE. It samples the
// opcode, operands and base select on the edge that leaves IDLE, then
// stays in EXEC for NATIVE_LAT or FOREIGN_LAT cycles. Which latency applies
// depends on whether the selected base unit is native for the opcode. The
// registered result appears together with a one-cycle done pulse.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   operation    [3:0]  opcode (0 ADD .. 8 SHR; 9-15 produce 0)
//   operand_a    [31:0] first operand
//   operand_b    [31:0] second operand / shift amount
//   base_select  [1:0]  0 base-2, 1 base-10, 2 base-12, 3 aliases base-2
//   result       [31:0] result of the last completed operation
//   done         one-cycle pulse while in DONE
module router #(
  parameter int NATIVE_LAT  = 1,
  parameter int FOREIGN_LAT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  operation,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [1:0]  base_select,
  output logic [31:0] result,
  output logic        done
);

  localparam int CW = 16;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t        state;
  logic [3:0]    op_q;
  logic [31:0]   a_q, b_q;
  logic [1:0]    base_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] lat_sel;
  logic [31:0]   alu_out;
  logic          native;
  logic [1:0]    base_eff;

  // The native check uses the live inputs because the latency is loaded on
  // the same edge that captures them.
  always_comb begin
    base_eff = (base_select == 2'd3) ? 2'd0 : base_select;
    native   = 1'b1;
    if (operation <= 4'd2)      native = (base_eff == 2'd0);
    else if (operation <= 4'd5) native = (base_eff == 2'd1);
    else if (operation <= 4'd8) native = (base_eff == 2'd2);
    lat_sel  = native ? CW'(NATIVE_LAT) : CW'(FOREIGN_LAT);
  end

  // Results are base-independent; the base only affects timing.
  always_comb begin
    alu_out = 32'd0;
    case (op_q)
      4'd0: alu_out = a_q + b_q;
      4'd1: alu_out = a_q - b_q;
      4'd2: alu_out = a_q * b_q;
      4'd3: alu_out = (b_q == 32'd0) ? 32'hFFFF_FFFF : a_q / b_q;
      4'd4: alu_out = a_q & b_q;
      4'd5: alu_out = a_q | b_q;
      4'd6: alu_out = a_q ^ b_q;
      4'd7: alu_out = a_q << b_q[4:0];
      4'd8: alu_out = a_q >> b_q[4:0];
      default: alu_out = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      result <= 32'd0;
      done   <= 1'b0;
      op_q   <= 4'd0;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      base_q <= 2'd0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done   <= 1'b0;
          op_q   <= operation;
          a_q    <= operand_a;
          b_q    <= operand_b;
          base_q <= base_select;
          cnt    <= lat_sel;
          state  <= EXEC;
        end
        EXEC: begin
          // A latency of 0 is treated as a single EXEC cycle.
          if (cnt <= CW'(1)) begin
            result <= alu_out;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // The latched base only steers the latency decision; it is kept for
  // observability of the captured request.
  logic unused_base;
  assign unused_base = ^base_q;

endmodule

// File: tb/tb_router.sv
module tb_router;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  operation = 4'd0;
  logic [31:0] operand_a = 32'd0;
  logic [31:0] operand_b = 32'd0;
  logic [1:0]  base_select = 2'd0;
  logic [31:0] result;
  logic        done;

  router #(.NATIVE_LAT(1), .FOREIGN_LAT(4)) dut (
    .clk(clk), .reset(reset), .operation(operation),
    .operand_a(operand_a), .operand_b(operand_b),
    .base_select(base_select), .result(result), .done(done)
  );

  always #5 clk = ~clk;

  // cyc counts cycles since reset release; the cycle following the last
  // reset edge is cycle 0.
  int cyc = 0;
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          at;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Monitor: every done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done cycle=%0d result=%h required=no pulse", cyc, result);
      end else begin
        e = exp_q.pop_front();
        if (result !== e.res || cyc != e.at) begin
          errors++;
          $display("FAIL done_result got %h at cycle %0d, required %h at cycle %0d",
                   result, cyc, e.res, e.at);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, req);
    end
  endtask

  task automatic push(input logic [31:0] r, input int at);
    exp_t e;
    e.res = r;
    e.at  = at;
    exp_q.push_back(e);
  endtask

  // Assert reset for one edge, check reset state, then release it with the
  // given request already driven so that it is captured at the end of cycle 0.
  task automatic start(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [1:0] bs);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    check("reset_result", result, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    operation = op; operand_a = a; operand_b = b; base_select = bs;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // One operation held constant; expects pulses at dcyc and dcyc+period.
  task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [1:0] bs, input logic [31:0] r, input int dcyc,
                     input bit twice);
    start(op, a, b, bs);
    push(r, dcyc);
    if (twice) push(r, 2 * dcyc + 1);
    wait_cyc(twice ? 2 * dcyc + 2 : dcyc + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    run(4'd0, 32'h1234,     32'h5678,     2'd0, 32'h0000_68AC, 2, 1'b1);
    run(4'd2, 32'hFF,       32'hAA,       2'd0, 32'h0000_A956, 2, 1'b0);
    run(4'd2, 32'hFF,       32'hAA,       2'd1, 32'h0000_A956, 5, 1'b0);
    run(4'd1, 32'hFFFF,     32'h1111,     2'd2, 32'h0000_EEEE, 5, 1'b1);
    run(4'd3, 32'd100,      32'd10,       2'd1, 32'd10,        2, 1'b0);
    run(4'd8, 32'd144,      32'd4,        2'd2, 32'd9,         2, 1'b0);
    run(4'd3, 32'd7,        32'd0,        2'd1, 32'hFFFF_FFFF, 2, 1'b0);
    run(4'd12, 32'h1234,    32'h5678,     2'd0, 32'd0,         2, 1'b0);
    run(4'd12, 32'h1234,    32'h5678,     2'd2, 32'd0,         2, 1'b0);
    run(4'd6, 32'hF0F0,     32'h0FF0,     2'd2, 32'h0000_FF00, 2, 1'b0);
    run(4'd7, 32'd1,        32'd33,       2'd2, 32'd2,         2, 1'b0);
    run(4'd4, 32'hFF00FF00, 32'h0FF00FF0, 2'd1, 32'h0F000F00, 2, 1'b0);
    run(4'd5, 32'hF0,       32'h0F,       2'd0, 32'hFF,        5, 1'b0);
    run(4'd0, 32'hFFFFFFFF, 32'd2,        2'd0, 32'd1,         2, 1'b0);
    run(4'd2, 32'd3,        32'd5,        2'd3, 32'd15,        2, 1'b0);
    run(4'd1, 32'd5,        32'd7,        2'd3, 32'hFFFF_FFFE, 2, 1'b0);
    run(4'd3, 32'd9,        32'd3,        2'd3, 32'd3,         5, 1'b0);

    // Operands changed mid-EXEC must not affect the result.
    start(4'd1, 32'd10, 32'd3, 2'd2);
    push(32'd7, 5);
    wait_cyc(2);
    operand_a = 32'd1000; operand_b = 32'd1; operation = 4'd0;
    wait_cyc(6);

    // Reset during a foreign-latency EXEC aborts it and clears result.
    start(4'd0, 32'd1, 32'd1, 2'd0);
    push(32'd2, 2);
    wait_cyc(3);
    operation = 4'd1; operand_a = 32'd50; operand_b = 32'd8; base_select = 2'd2;
    wait_cyc(6);
    check("pre_abort_result", result, 32'd2);
    reset = 1'b1;
    @(negedge clk);
    check("abort_result", result, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    repeat (6) @(negedge clk);
    check("abort_hold_result", result, 32'd0);

    // Normal operation resumes after the abort.
    run(4'd6, 32'hAAAA, 32'h5555, 2'd2, 32'hFFFF, 2, 1'b0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_done pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/router.md
ROUTER -- requirements
Module: router

Interface
REQ-001 Parameter NATIVE_LAT, default 1: EXEC cycles when the selected base unit is native for the operation.
REQ-002 Parameter FOREIGN_LAT, default 4: EXEC cycles when the selected base unit is not native for the operation.
REQ-003 clk  input  1: single clock; all state changes on the rising edge.
REQ-004 reset  input  1: synchronous, active-high reset.
REQ-005 operation  input  4: opcode, decoded per REQ-012.
REQ-006 operand_a  input  32: first operand, unsigned.
REQ-007 operand_b  input  32: second operand or shift amount, unsigned.
REQ-008 base_select  input  2: 0 = base-2 unit, 1 = base-10 unit, 2 = base-12 unit, 3 = treated as base-2.
REQ-009 result  output  32: registered result of the last completed operation.
REQ-010 done  output  1: one-cycle pulse marking result valid.

Function
REQ-011 FSM states: IDLE, EXEC, DONE; the block runs continuously with no start input.
REQ-012 Opcodes (binary results, identical for every base):
- 0 ADD: a+b mod 2^32
- 1 SUB: a-b mod 2^32
- 2 MUL: low 32 bits of a*b
- 3 DIV: unsigned a/b; b=0 gives 32'hFFFFFFFF
- 4 AND
- 5 OR
- 6 XOR
- 7 SHL: a<<b[4:0]
- 8 SHR: logical a>>b[4:0]
- 9-15: result 0
REQ-013 Native mapping:
- ops 0-2 native to base-2
- ops 3-5 native to base-10
- ops 6-8 native to base-12
- ops 9-15 native to every base
REQ-014 IDLE lasts one cycle; on the edge leaving IDLE, operation, operand_a, operand_b and base_select are latched and a latency counter is loaded with L (NATIVE_LAT or FOREIGN_LAT per REQ-013).
REQ-015 EXEC lasts exactly L cycles; input changes during EXEC have no effect.
REQ-016 On the edge leaving EXEC, result is loaded from the latched operands and the state moves to DONE.
REQ-017 done is 1 only while in DONE (exactly one cycle); DONE always returns to IDLE.
REQ-018 Per-operation period is L+2 cycles; back-to-back operations repeat with no extra gap.
REQ-019 result holds its value between DONE cycles and changes only on entry to DONE.
REQ-020 done is registered, not combinational from the inputs.

Reset
REQ-021 While reset=1 at a rising edge: state<=IDLE, result<=0, done<=0, latched operands/opcode/base<=0, counter<=0.
REQ-022 Reset during EXEC or DONE aborts the operation; no done pulse is produced for it, and result reads 0 afterwards.
REQ-023 The first capture occurs on the edge ending the first IDLE cycle after reset deasserts (reset-release cycle = cycle 0).

Verification
REQ-024 ADD, a=0x1234, b=0x5678, base 0, inputs held from cycle 0 -> done=1 in cycle 2 with result=0x000068AC; done pulses again in cycle 5.
REQ-025 MUL, a=0xFF, b=0xAA, base 0 -> result=0x0000A956, done in cycle 2; same op with base 1 -> done in cycle 5 with the identical result.
REQ-026 SUB, a=0xFFFF, b=0x1111, base 2 (foreign) -> done in cycle 5, result=0x0000EEEE; DIV 100/10, base 1 -> done in cycle 2, result=10.
REQ-027 SHR, a=144, b=4, base 2 -> result=9, done in cycle 2; DIV, a=7, b=0 -> result=0xFFFFFFFF; opcode 12 -> result=0.
REQ-028 Reset asserted in cycle 3 of a foreign-latency operation -> no done pulse, result=0; operands changed mid-EXEC do not alter the result.
